// File: rtl/rsa_precompute_ctrl_if.sv
// Handshake and operand-RAM signal bundle for the RSA precompute sequencer.
// The slave modport is the controller; the master modport is the surrounding front end.
interface rsa_precompute_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  start;
  logic                  abort;
  logic                  pre_start;
  logic                  pre_done;
  logic [DATA_WIDTH-1:0] n0p_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] r_in;
  logic [DATA_WIDTH-1:0] t_in;
  logic                  mem_we;
  logic                  mem_sel;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] n0p_out;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, abort, pre_done, n0p_in, in_valid, r_in, t_in,
    input  pre_start, in_ready, mem_we, mem_sel, mem_addr, mem_wdata,
           n0p_out, busy, done, err
  );

  modport slave (
    input  start, abort, pre_done, n0p_in, in_valid, r_in, t_in,
    output pre_start, in_ready, mem_we, mem_sel, mem_addr, mem_wdata,
           n0p_out, busy, done, err
  );
endinterface

// File: rtl/rsa_precompute_ctrl.sv
// Key-load sequencer: kicks the modulus precompute, captures n0', then streams
// r/t word pairs (MS word first) into the r and t regions of the operand RAM.
module rsa_precompute_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rsa_precompute_ctrl_if.slave  bus_if
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KICK   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_XFER_R = 3'd3;
  localparam logic [2:0] S_XFER_T = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] t_hold_q, t_hold_d;
  logic                  fin_q, fin_d;
  logic                  pre_start_q, pre_start_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_sel_q, mem_sel_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] n0p_q, n0p_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    t_hold_d    = t_hold_q;
    fin_d       = 1'b0;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    n0p_d       = n0p_q;
    err_d       = err_q;
    // fin_q marks the cycle of the final t write; done follows it by one cycle
    done_d      = fin_q;

    if (bus_if.abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_if.start) begin
            state_d = S_KICK;
            err_d   = 1'b0;
            idx_d   = {ADDR_WIDTH{1'b1}};
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_KICK: state_d = S_WAIT;
        S_WAIT: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus_if.pre_done) begin
            n0p_d   = bus_if.n0p_in;
            state_d = S_XFER_R;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_XFER_R: begin
          if (bus_if.in_valid) begin
            t_hold_d    = bus_if.t_in;
            mem_we_d    = 1'b1;
            mem_sel_d   = 1'b0;
            mem_addr_d  = idx_q;
            mem_wdata_d = bus_if.r_in;
            state_d     = S_XFER_T;
          end else begin
            state_d = S_XFER_R;
          end
        end
        S_XFER_T: begin
          mem_we_d    = 1'b1;
          mem_sel_d   = 1'b1;
          mem_addr_d  = idx_q;
          mem_wdata_d = t_hold_q;
          if (idx_q == {ADDR_WIDTH{1'b0}}) begin
            state_d = S_IDLE;
            fin_d   = 1'b1;
          end else begin
            idx_d   = idx_q - ADDR_WIDTH'(1);
            state_d = S_XFER_R;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    pre_start_d = (state_d == S_KICK);
    busy_d      = (state_d != S_IDLE) | fin_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= {ADDR_WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      t_hold_q    <= {DATA_WIDTH{1'b0}};
      fin_q       <= 1'b0;
      pre_start_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q <= {DATA_WIDTH{1'b0}};
      n0p_q       <= {DATA_WIDTH{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      t_hold_q    <= t_hold_d;
      fin_q       <= fin_d;
      pre_start_q <= pre_start_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      n0p_q       <= n0p_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus_if.in_ready  = (state_q == S_XFER_R);
  assign bus_if.pre_start = pre_start_q;
  assign bus_if.mem_we    = mem_we_q;
  assign bus_if.mem_sel   = mem_sel_q;
  assign bus_if.mem_addr  = mem_addr_q;
  assign bus_if.mem_wdata = mem_wdata_q;
  assign bus_if.n0p_out   = n0p_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.done      = done_q;
  assign bus_if.err       = err_q;
endmodule

// File: tb/tb_rsa_precompute_ctrl.sv
// Scenario bench for rsa_precompute_ctrl: expected RAM writes are queued as pairs
// are driven and matched against writes captured from the DUT.
module tb_rsa_precompute_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;
  localparam int NW = 32;

  typedef logic [DW+AW:0] wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rsa_precompute_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  rsa_precompute_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_t_cyc = 0;
  int   xt_viol = 0;
  logic done_busy = 1'b0;
  wr_t  exp_q[$];
  wr_t  obs_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: capture writes, done pulses and in_ready during the r-write cycle
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_we) obs_q.push_back({bus.mem_sel, bus.mem_addr, bus.mem_wdata});
      if (bus.mem_we && bus.mem_sel && bus.mem_addr == 5'd0) last_t_cyc <= cyc;
      if (bus.mem_we && !bus.mem_sel && bus.in_ready) xt_viol <= xt_viol + 1;
      if (bus.done) begin
        done_cnt  <= done_cnt + 1;
        done_cyc  <= cyc;
        done_busy <= bus.busy;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int pre_delay, input int gap, input int npairs,
                          input logic [DW-1:0] n0p, input logic [DW-1:0] rbase,
                          input logic [DW-1:0] tbase);
    int bound;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (pre_delay) step();
    bus.pre_done = 1'b1;
    bus.n0p_in   = n0p;
    step();
    bus.pre_done = 1'b0;
    bus.n0p_in   = ~n0p;
    for (int k = 0; k < npairs; k++) begin
      if (k > 0) repeat (gap) step();
      bus.r_in     = rbase + DW'(k);
      bus.t_in     = tbase + DW'(k);
      bus.in_valid = 1'b1;
      bound = 0;
      while (!bus.in_ready && bound < 100) begin
        step();
        bound++;
      end
      n_checks++;
      if (bound >= 100) begin
        n_fail++;
        $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", bus.in_ready, bound);
        bus.in_valid = 1'b0;
        return;
      end
      exp_q.push_back({1'b0, AW'(NW - 1 - k), rbase + DW'(k)});
      exp_q.push_back({1'b1, AW'(NW - 1 - k), tbase + DW'(k)});
      step();
      bus.in_valid = 1'b0;
    end
    if (npairs == NW) repeat (6) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.pre_start, bus.in_ready, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata,
         bus.n0p_out, bus.busy, bus.done, bus.err} !== 73'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b err=%b mem_we=%b n0p_out=%h, required all zero",
               bus.busy, bus.err, bus.mem_we, bus.n0p_out);
    end
    #12 rst_n = 1'b1;
    step();
  endtask

  task automatic test_nominal();
    int d0;
    wr_t e, o;
    d0 = done_cnt;
    exp_q.delete(); obs_q.delete();
    run_load(10, 0, NW, 32'hDEADBEEF, 32'h1000_0000, 32'h2000_0000);
    n_checks++;
    if (bus.n0p_out !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL nom_n0p: got %h required %h", bus.n0p_out, 32'hDEADBEEF);
    end
    n_checks++;
    if (obs_q.size() != 64) begin
      n_fail++; $display("FAIL nom_wcount: got %0d required %0d", obs_q.size(), 64);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL nom_write: got %h required %h", o, e); end
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL nom_done_count: got %0d required 1", done_cnt - d0);
    end
    n_checks++;
    if (done_cyc != last_t_cyc + 1 || done_busy !== 1'b0) begin
      n_fail++; $display("FAIL nom_done_timing: done cycle %0d busy %b, required cycle %0d busy 0",
                         done_cyc, done_busy, last_t_cyc + 1);
    end
  endtask

  task automatic test_throttled();
    int d0, v0;
    wr_t e, o;
    d0 = done_cnt; v0 = xt_viol;
    exp_q.delete(); obs_q.delete();
    run_load(4, 3, NW, 32'hCAFEF00D, 32'h1000_0000, 32'h2000_0000);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL thr_wcount: got %0d required %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL thr_write: got %h required %h", o, e); end
    end
    n_checks++;
    if (xt_viol != v0) begin
      n_fail++; $display("FAIL thr_ready_in_xfer_t: got %0d cycles required 0", xt_viol - v0);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL thr_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_timeout();
    int d0;
    logic ok;
    d0 = done_cnt;
    obs_q.delete();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if (bus.pre_start !== 1'b1 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL to_kick: pre_start=%b busy=%b required 1 1", bus.pre_start, bus.busy);
    end
    ok = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      bus.start = (i == 5);
      step();
      if (bus.err !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
    end
    bus.start = 1'b0;
    n_checks++;
    if (ok !== 1'b1) begin
      n_fail++; $display("FAIL to_wait: err/busy changed early (ok=%b) required err 0 busy 1", ok);
    end
    step();
    n_checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL to_err: err=%b busy=%b required 1 0", bus.err, bus.busy);
    end
    bus.pre_done = 1'b1; bus.n0p_in = 32'h12345678;
    step();
    bus.pre_done = 1'b0;
    step();
    n_checks++;
    if (bus.n0p_out !== 32'hCAFEF00D || obs_q.size() != 0 || done_cnt != d0) begin
      n_fail++; $display("FAIL to_quiet: n0p_out=%h writes=%0d dones=%0d required cafef00d 0 0",
                         bus.n0p_out, obs_q.size(), done_cnt - d0);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n_checks++;
    if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL to_restart: err=%b busy=%b required 0 1", bus.err, bus.busy);
    end
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL to_abort_idle: busy=%b err=%b required 0 0", bus.busy, bus.err);
    end
  endtask

  task automatic test_timeout_tie();
    int d0;
    wr_t e, o;
    d0 = done_cnt;
    exp_q.delete(); obs_q.delete();
    run_load(TO, 0, NW, 32'h0BADF00D, 32'h5000_0000, 32'h6000_0000);
    n_checks++;
    if (bus.err !== 1'b0 || bus.n0p_out !== 32'h0BADF00D) begin
      n_fail++; $display("FAIL tie_err: err=%b n0p_out=%h required 0 0badf00d", bus.err, bus.n0p_out);
    end
    n_checks++;
    if (obs_q.size() != 64 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL tie_xfer: writes=%0d dones=%0d required 64 1", obs_q.size(), done_cnt - d0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL tie_write: got %h required %h", o, e); end
    end
  endtask

  task automatic test_abort();
    int d0;
    wr_t e, o, dropped;
    d0 = done_cnt;
    exp_q.delete(); obs_q.delete();
    run_load(10, 0, 5, 32'h11112222, 32'h7000_0000, 32'h8000_0000);
    dropped = exp_q.pop_back();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    n_checks++;
    if (bus.mem_we !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL abort_outputs: mem_we=%b busy=%b done=%b required 0 0 0",
                         bus.mem_we, bus.busy, bus.done);
    end
    repeat (3) step();
    n_checks++;
    if (obs_q.size() != 9 || done_cnt != d0) begin
      n_fail++; $display("FAIL abort_writes: writes=%0d dones=%0d required 9 0", obs_q.size(), done_cnt - d0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL abort_write: got %h required %h", o, e); end
    end
    exp_q.delete(); obs_q.delete();
    run_load(10, 0, NW, 32'h5A5A5A5A, 32'h3000_0000, 32'h4000_0000);
    n_checks++;
    if (obs_q.size() != 64 || done_cnt - d0 != 1) begin
      n_fail++; $display("FAIL reload_xfer: writes=%0d dones=%0d required 64 1", obs_q.size(), done_cnt - d0);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL reload_write: got %h required %h", o, e); end
    end
    bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pre_start !== 1'b0) begin
      n_fail++; $display("FAIL abort_start_idle: busy=%b pre_start=%b required 0 0", bus.busy, bus.pre_start);
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); obs_q.delete();
    run_load(10, 0, 3, 32'h99998888, 32'hA000_0000, 32'hB000_0000);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.pre_start, bus.in_ready, bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata,
         bus.n0p_out, bus.busy, bus.done, bus.err} !== 73'd0) begin
      n_fail++; $display("FAIL rst_mid_outputs: mem_we=%b addr=%0d wdata=%h n0p_out=%h busy=%b, required all zero",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.n0p_out, bus.busy);
    end
    bus.start = 1'b1;
    repeat (3) step();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.pre_start !== 1'b0) begin
      n_fail++; $display("FAIL rst_start_ignored: busy=%b pre_start=%b required 0 0", bus.busy, bus.pre_start);
    end
    bus.start = 1'b0;
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_idle: busy=%b required 0", bus.busy);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.pre_done = 1'b0; bus.n0p_in = '0;
    bus.in_valid = 1'b0; bus.r_in = '0; bus.t_in = '0;
    test_reset();
    test_nominal();
    test_throttled();
    test_timeout();
    test_timeout_tie();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rsa_precompute_ctrl.md
# rsa_precompute_ctrl

Sequencer for the RSA decryption front end. It launches the modulus-dependent precompute (n0', r = R mod n, t = R² mod n), waits for completion with a timeout, and captures n0'. It then accepts the 32-bit r/t word stream, most-significant word first, and writes both into the shared single-port operand RAM ahead of the Montgomery core. It is the only writer of the r/t operand regions during key load.

## Interface
- DATA_WIDTH, 32, operand word width
- ADDR_WIDTH, 5, operand RAM word address width; words per operand = 2^ADDR_WIDTH (32 → 1024 bits)
- TIMEOUT, 4096, max cycles spent in WAIT_PRE before error

Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a key load; accepted only in IDLE
- abort  in  1  cancel current load; highest priority
- pre_start  out  1  one-cycle pulse starting the precompute block
- pre_done  in  1  precompute complete (pulse or level)
- n0p_in  in  DATA_WIDTH  n0' from precompute; valid when pre_done=1
- in_valid  in  1  r_in/t_in hold a word pair
- in_ready  out  1  controller accepts a pair this cycle
- r_in, t_in  in  DATA_WIDTH  r and t words, MS word first
- mem_we  out  1  operand RAM write strobe
- mem_sel  out  1  region select: 0 = r, 1 = t
- mem_addr  out  ADDR_WIDTH  word address (0 = least significant)
- mem_wdata  out  DATA_WIDTH  write data
- n0p_out  out  DATA_WIDTH  captured n0', held until next accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, load finished
- err  out  1  timeout flag, sticky until next accepted start or reset

## Operation
- States: IDLE, KICK, WAIT_PRE, XFER_R, XFER_T.
- IDLE: start=1 → KICK. Clears err, word index := 2^ADDR_WIDTH−1, timeout counter := 0. n0p_out is held.
- KICK: pre_start=1 for this cycle only. Next state is WAIT_PRE.
- WAIT_PRE: counter increments each cycle. pre_done=1 → n0p_out := n0p_in, then XFER_R. If counter = TIMEOUT−1 and pre_done=0 → err := 1, IDLE, no done. If pre_done and the timeout fall in the same cycle, pre_done wins.
- XFER_R: in_ready=1. On in_valid, latch r_in/t_in into hold registers and go to XFER_T. The cycle after acceptance drives mem_we=1, mem_sel=0, mem_addr=index, mem_wdata=r.
- XFER_T: in_ready=0. Drives mem_we=1, mem_sel=1, same index, wdata=t. If index=0 → done pulse next cycle, IDLE. Otherwise index −1 and back to XFER_R.
- Index arithmetic is unsigned ADDR_WIDTH, with no wrap: index 0 ends the transfer.
- in_ready=0 outside XFER_R. Words offered then are not consumed.
- start while busy: ignored.
- abort=1 in any state → IDLE next cycle. mem_we is forced low from that cycle. No done, err unchanged. abort together with start in IDLE: stay IDLE.
- A pre_done pulse seen outside WAIT_PRE is ignored.

## Timing
- Reset values: pre_start=0, in_ready=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, n0p_out=0, busy=0, done=0, err=0, state IDLE.
- All outputs are registered, except in_ready, which is decoded from state.
- start sampled at edge E → busy=1 and pre_start=1 in cycle E+1.
- pre_done sampled at edge P → n0p_out valid from P+1, in_ready=1 from P+1.
- Pair accepted at edge A → r write in cycle A+1, t write in A+2. The next pair can be accepted at edge A+2, so the best case is one pair per 2 cycles.
- Minimum load: pre_done-to-done is 64 write cycles + 1.
- done is high in the cycle after the final t write (address 0). busy falls in that same cycle.

## Test plan
- Nominal load: pre_done after 10 cycles with n0p_in=0xDEADBEEF, 32 back-to-back pairs r=0x1000_0000+k, t=0x2000_0000+k (k=0 first). Required: n0p_out=0xDEADBEEF, 64 writes, r word k at addr 31−k then t at addr 31−k, one done pulse.
- Throttled stream: in_valid low for 3 cycles between every pair. Required: identical RAM contents, no extra or duplicate writes, in_ready never high in XFER_T.
- Timeout: TIMEOUT=16, pre_done never asserted. Required: err=1 sixteen cycles after KICK, busy=0, no writes, no done. A new start clears err.
- Timeout tie: pre_done on exactly cycle TIMEOUT−1. Required: err stays 0 and the transfer proceeds.
- Abort mid-transfer after 5 pairs. Required: mem_we low from the next cycle, busy=0, done=0. A subsequent full load rewrites all 32 addresses correctly.
- Reset mid-XFER_T: rst_n low asynchronously. Required: all outputs immediately at reset values, and start is ignored until rst_n is released.
